fetch_sequencer: RTL
====================

# fetch_sequencer

Front-end controller that owns the program counter register and sequences instruction fetch. It drives the PC's branch, jump and advance controls and issues one-outstanding requests to instruction memory. It buffers returned instructions in a 2-entry queue toward decode. On a control-flow redirect it squashes in-flight and buffered fetches.

## Interface
- ADDR_W, 16, instruction address width; matches the `addr` type.
- INST_W, 32, instruction word width.

- clk  in  1  system clock, all state on rising edge
- rst  in  1  asynchronous, active-low reset
- pc  in  ADDR_W  current PC register value
- do_branch  out  1  PC load from branch_address
- branch_address  out  ADDR_W  branch target to PC
- do_jump  out  1  PC load from jump_address
- jump_address  out  ADDR_W  jump target to PC
- consumed_inst  out  1  PC advance by 1; holds when 0
- imem_req  out  1  fetch request valid
- imem_addr  out  ADDR_W  fetch address, equal to pc
- imem_ready  in  1  memory accepts request this cycle
- imem_valid  in  1  response valid; at least 1 cycle after accept
- imem_data  in  INST_W  response word
- ex_branch_taken  in  1  execute stage redirect
- ex_branch_target  in  ADDR_W  execute redirect target
- id_jump  in  1  decode stage redirect
- id_jump_target  in  ADDR_W  decode redirect target
- inst_valid  out  1  buffer head valid
- inst  out  INST_W  buffer head instruction
- inst_pc  out  ADDR_W  address of buffer head
- inst_ready  in  1  decode accepts head

## Operation
- The redirect signal is `ex_branch_taken | id_jump`, and branch takes priority.
  - do_branch = ex_branch_taken.
  - do_jump = id_jump & ~ex_branch_taken.
  - Both are combinational. Targets pass straight through.
- States: IDLE, REQ, WAIT, DRAIN.
- IDLE: the state after reset. It moves to REQ unconditionally. No request is issued and redirects are ignored.
- REQ:
  - imem_req = ~redirect & (count ≤ 1), where count is the buffer occupancy.
  - When imem_req & imem_ready:
    - consumed_inst = 1.
    - req_pc <= pc.
    - Go to WAIT.
  - Otherwise stay in REQ.
  - A dropped request, where imem_req falls before ready, is legal. Memory acts only on imem_req & imem_ready.
- WAIT:
  - imem_valid & ~redirect: push {imem_data, req_pc}, then go to REQ.
  - imem_valid & redirect: drop the response, then go to REQ.
  - ~imem_valid & redirect: go to DRAIN.
- DRAIN: wait for imem_valid, drop the word, then go to REQ. Further redirects in this state only drive the PC.
- consumed_inst is 0 outside accepted REQ cycles. It is always 0 in a redirect cycle.
- Buffer:
  - It is a 2-entry FIFO with a head pointer and count.
  - Pop occurs on inst_valid & inst_ready.
  - Push and pop in the same cycle leave count unchanged.
  - Redirect clears count to 0 and ignores any pop or push that cycle.
  - Overflow cannot occur, because an issue requires count ≤ 1 with at most 1 outstanding. Verification must assert count ≤ 2 and never push when full.
- Reset values:
  - state = IDLE, count = 0, req_pc = 0.
  - All outputs are 0 apart from the combinational pass-throughs.
  - Reset mid-WAIT abandons the outstanding fetch. A late imem_valid after reset is ignored, because the state is IDLE or REQ.

## Timing
- Request accepted at cycle N:
  - PC = old pc + 1 at N+1.
  - The response arrives at N+k, with k ≥ 1.
  - inst_valid rises at N+k+1 (registered buffer).
- Back-to-back issue: the next request can be issued in the cycle after the response. Peak rate is 1 instruction per 2 cycles with a 1-cycle memory.
- Redirect at cycle T:
  - The PC loads the target at the T+1 edge.
  - The first target fetch is issued at T+1, or after DRAIN completes.
  - inst_valid = 0 from T+1 until the target word is pushed.
- Address arithmetic wraps modulo 2^ADDR_W; the PC owns the increment.

## Test plan
- Reset, then memory with 1-cycle latency, pc = 0, inst_ready = 1:
  - Requests are issued at 0,1,2,… every 2 cycles.
  - inst_pc is 0,1,2 in order, with matching data.
  - consumed_inst pulses once per accept.
- inst_ready = 0 after reset: exactly 2 fetches complete, then imem_req stays 0 with count = 2. Raising inst_ready resumes fetch at address 2.
- ex_branch_taken with target 0x40 in WAIT, memory latency 3:
  - State goes to DRAIN and the stale word is dropped.
  - The next imem_addr is 0x40.
  - The buffer is empty in between.
- ex_branch_taken (target 0x80) and id_jump (target 0x20) in the same cycle: do_branch = 1, do_jump = 0, and the next fetch address is 0x80.
- Redirect in the same cycle as imem_valid with count = 1:
  - The word is dropped and count = 0 next cycle.
  - Pop is ignored and there is no duplicate delivery.
- Assert rst low mid-WAIT, release it, then pulse a late imem_valid: there is no push, state goes IDLE then REQ, and the first fetch address is 0.

Source files
------------

// File: rtl/fetch_sequencer.sv
// Instruction-fetch front end: drives PC controls, issues single-outstanding
// fetches to instruction memory and buffers returned words toward decode.
module fetch_sequencer #(
  parameter int ADDR_W = 16,
  parameter int INST_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] pc,
  output logic              do_branch,
  output logic [ADDR_W-1:0] branch_address,
  output logic              do_jump,
  output logic [ADDR_W-1:0] jump_address,
  output logic              consumed_inst,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_ready,
  input  logic              imem_valid,
  input  logic [INST_W-1:0] imem_data,
  input  logic              ex_branch_taken,
  input  logic [ADDR_W-1:0] ex_branch_target,
  input  logic              id_jump,
  input  logic [ADDR_W-1:0] id_jump_target,
  output logic              inst_valid,
  output logic [INST_W-1:0] inst,
  output logic [ADDR_W-1:0] inst_pc,
  input  logic              inst_ready
);

  typedef enum logic [1:0] {IDLE, REQ, WAIT, DRAIN} state_t;

  state_t            state;
  logic [ADDR_W-1:0] req_pc;
  logic [INST_W-1:0] buf_data [2];
  logic [ADDR_W-1:0] buf_pc   [2];
  logic              head;
  logic [1:0]        count;

  logic redirect;
  logic issue;
  logic push;
  logic pop;
  logic tail;

  // Branch from execute outranks a jump from decode; targets pass straight to the PC.
  assign redirect       = ex_branch_taken | id_jump;
  assign do_branch      = ex_branch_taken;
  assign branch_address = ex_branch_target;
  assign do_jump        = id_jump & ~ex_branch_taken;
  assign jump_address   = id_jump_target;

  assign imem_req      = (state == REQ) & ~redirect & (count < 2'd2);
  assign imem_addr     = pc;
  assign issue         = imem_req & imem_ready;
  assign consumed_inst = issue;

  assign push = (state == WAIT) & imem_valid & ~redirect;
  assign pop  = inst_valid & inst_ready;
  assign tail = head ^ count[0];

  assign inst_valid = (count != 2'd0);
  assign inst       = buf_data[head];
  assign inst_pc    = buf_pc[head];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state  <= IDLE;
      req_pc <= '0;
    end else begin
      case (state)
        IDLE: state <= REQ;
        REQ: begin
          if (issue) begin
            req_pc <= pc;
            state  <= WAIT;
          end
        end
        WAIT: begin
          // A response arriving with a redirect is simply not pushed.
          if (imem_valid)    state <= REQ;
          else if (redirect) state <= DRAIN;
        end
        DRAIN: begin
          if (imem_valid) state <= REQ;
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count    <= '0;
      head     <= '0;
      buf_data <= '{default: '0};
      buf_pc   <= '{default: '0};
    end else if (redirect) begin
      count <= '0;
    end else begin
      if (push) begin
        buf_data[tail] <= imem_data;
        buf_pc[tail]   <= req_pc;
      end
      if (pop) head <= ~head;
      case ({push, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

endmodule
